// File: rtl/pll_reset_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and the
// default timing parameters.
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int DEF_RST_PULSE_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT     = 50000;
  localparam int DEF_STABLE_CYCLES    = 1024;
  localparam int DEF_MAX_RETRIES      = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two back-to-back flops, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock with
// bounded retries, then releases the system reset.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       soft_restart,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retries,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [1:0]       retries_r;
  logic [1:0]       retries_next_s;
  logic [1:0]       retry_inc_s;
  logic [7:0]       loss_r;
  logic [7:0]       loss_next_s;
  logic             locked_s;
  logic             pll_rst_r;
  logic             sys_reset_r;
  logic             ready_r;
  logic             fault_r;
  logic             pll_rst_next_s;
  logic             sys_reset_next_s;
  logic             ready_next_s;
  logic             fault_next_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // State, shared counter, bookkeeping counters and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r     <= ST_RESET_PLL;
      cnt_r       <= CNT_ZERO;
      retries_r   <= 2'd0;
      loss_r      <= 8'd0;
      pll_rst_r   <= 1'b1;
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      retries_r   <= retries_next_s;
      loss_r      <= loss_next_s;
      pll_rst_r   <= pll_rst_next_s;
      sys_reset_r <= sys_reset_next_s;
      ready_r     <= ready_next_s;
      fault_r     <= fault_next_s;
    end
  end

  // Next-state logic; soft_restart overrides every other transition
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    retries_next_s = retries_r;
    loss_next_s    = loss_r;
    retry_inc_s    = retries_r + 2'd1;
    if (soft_restart) begin
      state_next_s   = ST_RESET_PLL;
      cnt_next_s     = CNT_ZERO;
      retries_next_s = 2'd0;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (cnt_r == PULSE_LAST) begin
            state_next_s = ST_WAIT_LOCK;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next_s = ST_STABLE;
            cnt_next_s   = CNT_ZERO;
          end else if (cnt_r == LOCK_LAST) begin
            retries_next_s = retry_inc_s;
            cnt_next_s     = CNT_ZERO;
            if (retry_inc_s == RETRY_LIMIT) begin
              state_next_s = ST_FAULT;
            end else begin
              state_next_s = ST_RESET_PLL;
            end
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_next_s = ST_WAIT_LOCK;
            cnt_next_s   = CNT_ZERO;
          end else if (cnt_r == STABLE_LAST) begin
            state_next_s   = ST_RUN;
            cnt_next_s     = CNT_ZERO;
            retries_next_s = 2'd0;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_next_s = ST_RESET_PLL;
            cnt_next_s   = CNT_ZERO;
            if (loss_r != 8'hFF) begin
              loss_next_s = loss_r + 8'd1;
            end else begin
              loss_next_s = loss_r;
            end
          end else begin
            cnt_next_s = CNT_ZERO;
          end
        end
        ST_FAULT: begin
          cnt_next_s = CNT_ZERO;
        end
        default: begin
          state_next_s = ST_RESET_PLL;
          cnt_next_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the flops line up with state_r
  always_comb begin
    pll_rst_next_s   = 1'b1;
    sys_reset_next_s = 1'b1;
    ready_next_s     = 1'b0;
    fault_next_s     = 1'b0;
    case (state_next_s)
      ST_RESET_PLL: pll_rst_next_s = 1'b1;
      ST_WAIT_LOCK: pll_rst_next_s = 1'b0;
      ST_STABLE:    pll_rst_next_s = 1'b0;
      ST_RUN: begin
        pll_rst_next_s   = 1'b0;
        sys_reset_next_s = 1'b0;
        ready_next_s     = 1'b1;
      end
      ST_FAULT: fault_next_s = 1'b1;
      default:  pll_rst_next_s = 1'b1;
    endcase
  end

  assign pll_rst       = pll_rst_r;
  assign sys_reset     = sys_reset_r;
  assign ready         = ready_r;
  assign fault         = fault_r;
  assign retries       = retries_r;
  assign lock_loss_cnt = loss_r;
  assign state         = state_r;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: vector table, directed corner
// sequences and randomized traffic against a time-stamp based reference model.
module tb_pll_reset_seq;
  import pll_reset_seq_pkg::*;

  localparam int P_PULSE   = 4;
  localparam int P_TIMEOUT = 20;
  localparam int P_STABLE  = 8;
  localparam int P_MAXR    = 3;

  localparam int M_RST    = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAULT  = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_rst, sys_reset, ready, fault;
  logic [1:0] retries;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  // reference model: current mode, cycles spent in it, lock history
  int         m_mode = M_RST;
  int         m_time = 0;
  int         m_retries = 0;
  int         m_losses = 0;
  logic [1:0] m_hist = 2'b00;
  bit         m_valid = 1'b0;

  always #10 refclk = ~refclk;

  pll_reset_seq #(
    .RST_PULSE_CYCLES (P_PULSE),
    .LOCK_TIMEOUT     (P_TIMEOUT),
    .STABLE_CYCLES    (P_STABLE),
    .MAX_RETRIES      (P_MAXR)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .locked        (locked),
    .soft_restart  (soft_restart),
    .pll_rst       (pll_rst),
    .sys_reset     (sys_reset),
    .ready         (ready),
    .fault         (fault),
    .retries       (retries),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] mode_state(input int m);
    case (m)
      M_RST:    return ST_RESET_PLL;
      M_WAIT:   return ST_WAIT_LOCK;
      M_STABLE: return ST_STABLE;
      M_RUN:    return ST_RUN;
      default:  return ST_FAULT;
    endcase
  endfunction

  task automatic enter(input int m);
    m_mode = m;
    m_time = 0;
  endtask

  // advance the model by one refclk edge using the inputs present at that edge
  task automatic model_step();
    logic ls;
    ls = m_hist[1];
    if (rst) begin
      m_hist    = 2'b00;
      m_retries = 0;
      m_losses  = 0;
      m_valid   = 1'b1;
      enter(M_RST);
    end else begin
      m_hist = {m_hist[0], locked};
      if (soft_restart) begin
        m_retries = 0;
        enter(M_RST);
      end else begin
        m_time++;
        case (m_mode)
          M_RST: if (m_time == P_PULSE) enter(M_WAIT);
          M_WAIT: begin
            if (ls) enter(M_STABLE);
            else if (m_time == P_TIMEOUT) begin
              m_retries++;
              enter((m_retries == P_MAXR) ? M_FAULT : M_RST);
            end
          end
          M_STABLE: begin
            if (!ls) enter(M_WAIT);
            else if (m_time == P_STABLE) begin
              m_retries = 0;
              enter(M_RUN);
            end
          end
          M_RUN: begin
            if (!ls) begin
              if (m_losses < 255) m_losses++;
              enter(M_RST);
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    logic [16:0] act, exp;
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    if (m_valid) begin
      act = {state, pll_rst, sys_reset, ready, fault, retries, lock_loss_cnt};
      exp = {mode_state(m_mode), (m_mode == M_RST || m_mode == M_FAULT), (m_mode != M_RUN),
             (m_mode == M_RUN), (m_mode == M_FAULT), 2'(m_retries), 8'(m_losses)};
      check("model", 32'(act), 32'(exp));
    end
  endtask

  // leaves the bench in cycle 1: first cycle after the last reset edge
  task automatic do_reset();
    rst = 1'b1;
    soft_restart = 1'b0;
    locked = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    int         lock_at;
    int         rdy_at;
    int         pulses;
    logic       fault;
    logic [1:0] retries;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int   rdy, pulses, n;
    logic prev;
    logic [2:0] sr;

    tbl[0] = '{10, 21, 1, 1'b0, 2'd0};
    tbl[1] = '{5, 16, 1, 1'b0, 2'd0};
    tbl[2] = '{1, 14, 1, 1'b0, 2'd0};
    tbl[3] = '{24, 38, 2, 1'b0, 2'd0};
    tbl[4] = '{30, 41, 2, 1'b0, 2'd0};
    tbl[5] = '{60, 71, 3, 1'b0, 2'd0};
    tbl[6] = '{70, 81, 3, 1'b0, 2'd0};
    tbl[7] = '{72, 0, 4, 1'b1, 2'd3};
    tbl[8] = '{0, 0, 4, 1'b1, 2'd3};

    do_reset();
    check("reset_state", {state, pll_rst, sys_reset, ready, fault, retries, lock_loss_cnt},
          {ST_RESET_PLL, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});

    // table: lock arrival time versus ready time, pulse count and fault
    for (int i = 0; i < 9; i++) begin
      do_reset();
      rdy = 0;
      pulses = 0;
      prev = 1'b0;
      for (int c = 1; c <= 100; c++) begin
        if (ready && rdy == 0) rdy = c;
        if (pll_rst && !prev) pulses++;
        prev = pll_rst;
        locked = (tbl[i].lock_at != 0 && c >= tbl[i].lock_at);
        cycle();
      end
      check("tbl_ready_at", rdy, tbl[i].rdy_at);
      check("tbl_pulses", pulses, tbl[i].pulses);
      check("tbl_fault", fault, tbl[i].fault);
      check("tbl_retries", retries, tbl[i].retries);
    end

    // one-cycle lock glitch in STABLE restarts the stable window
    do_reset();
    rdy = 0;
    sr = 3'd0;
    for (int c = 1; c <= 40; c++) begin
      if (ready && rdy == 0) rdy = c;
      if (c == 18) sr = state;
      locked = (c >= 10 && c != 15);
      cycle();
    end
    check("glitch_ready_at", rdy, 27);
    check("glitch_state18", sr, ST_WAIT_LOCK);
    check("glitch_retries", retries, 2'd0);

    // repeated lock loss in RUN: saturating counter and sys_reset latency
    for (int k = 0; k < 300; k++) begin
      locked = 1'b0;
      cycle();
      locked = 1'b1;
      sr[2] = sys_reset;
      cycle();
      sr[1] = sys_reset;
      cycle();
      sr[0] = sys_reset;
      check("drop_sys_reset", sr, 3'b001);
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
        cycle();
        n++;
      end
      check("relock_ready", ready, 1'b1);
    end
    check("loss_saturated", lock_loss_cnt, 8'd255);

    // soft_restart coinciding with the first lock timeout
    do_reset();
    for (int c = 1; c <= 23; c++) cycle();
    soft_restart = 1'b1;
    cycle();
    soft_restart = 1'b0;
    check("soft_at_timeout", {state, retries, fault}, {ST_RESET_PLL, 2'd0, 1'b0});

    // run into FAULT, hold there, then leave it with soft_restart
    n = 0;
    while (fault !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    repeat (5) cycle();
    check("fault_hold", {fault, pll_rst, sys_reset, ready, retries}, {1'b1, 1'b1, 1'b1, 1'b0, 2'd3});
    soft_restart = 1'b1;
    cycle();
    soft_restart = 1'b0;
    check("soft_from_fault", {state, fault, retries, pll_rst}, {ST_RESET_PLL, 1'b0, 2'd0, 1'b1});

    // rst in the middle of STABLE
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      locked = (c >= 10);
      cycle();
    end
    check("pre_rst_stable", state, ST_STABLE);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_stable", {state, pll_rst, sys_reset, ready, fault, retries, lock_loss_cnt},
          {ST_RESET_PLL, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 3) locked = ~locked;
      soft_restart = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;
    soft_restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
